// File: rtl/dll_pkg.sv
// dll_pkg: shared pointer types and constants for the doubly-linked-list queue engine.
package dll_pkg;
    localparam int PTR_N = 255;
    localparam int PTR_W = $clog2(PTR_N);
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_N-1:0] ptr_d_t;
    typedef logic [PTR_W-1:0] cnt_t;
    localparam ptr_t PTR_NULL = '0;
    localparam ptr_t PTR_FIRST = ptr_t'(1);
    localparam ptr_t PTR_LAST = ptr_t'(PTR_N - 1);
    localparam cnt_t CNT_MAX = cnt_t'(PTR_N - 1);
endpackage

// File: rtl/dll_ffs.sv
// dll_ffs: lowest-set-bit finder built as a log-depth binary tree over a padded vector.
module dll_ffs
    import dll_pkg::*;
#(
    parameter int N = PTR_N,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] bits,
    output logic         vld,
    output logic [W-1:0] idx
);
    localparam int P = 1 << W;
    genvar l, i;
    generate
        for (l = 0; l <= W; l++) begin : g_lv
            logic [(P>>l)-1:0] v;
            logic [W-1:0]      x [P>>l];
            for (i = 0; i < (P >> l); i++) begin : g_nd
                if (l == 0) begin : g_leaf
                    if (i < N) begin : g_in
                        assign v[i] = bits[i];
                    end else begin : g_pad
                        assign v[i] = 1'b0;
                    end
                    assign x[i] = W'(i);
                end else begin : g_node
                    // left child wins so the lowest index propagates up
                    assign v[i] = g_lv[l-1].v[2*i] | g_lv[l-1].v[2*i+1];
                    assign x[i] = g_lv[l-1].v[2*i] ? g_lv[l-1].x[2*i] : g_lv[l-1].x[2*i+1];
                end
            end
        end
    endgenerate
    assign vld = g_lv[W].v[0];
    assign idx = g_lv[W].x[0];
endmodule

// File: rtl/dll_ptr_alloc.sv
// dll_ptr_alloc: free-pointer allocator presenting one pre-selected free pointer per cycle.
module dll_ptr_alloc
    import dll_pkg::*;
(
    input  logic clk,
    input  logic rst,
    output logic alloc_vld,
    output ptr_t alloc_ptr,
    input  logic alloc_rdy,
    input  logic free_vld,
    input  ptr_t free_ptr,
    output cnt_t free_cnt,
    output logic err_bad_ptr,
    output logic err_dbl_free
);
    ptr_d_t free_r, free_nxt;
    logic   alloc_vld_r, err_bad_r, err_dbl_r;
    ptr_t   alloc_ptr_r, pick_idx;
    cnt_t   free_cnt_r;
    logic   pick_vld, hs, refill, bad, dbl, legal;

    dll_ffs #(.N(PTR_N), .W(PTR_W)) u_ffs (
        .bits(free_r),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    always_comb begin
        hs = alloc_vld_r & alloc_rdy;
        refill = ~alloc_vld_r | alloc_rdy;
        bad = free_vld & (free_ptr == PTR_NULL || free_ptr > PTR_LAST);
        dbl = free_vld & ~bad & (free_r[free_ptr] | (alloc_vld_r & free_ptr == alloc_ptr_r));
        legal = free_vld & ~bad & ~dbl;
        free_nxt = free_r;
        // picking uses the old bitmap, so a pointer freed now waits one cycle
        if (refill & pick_vld) free_nxt[pick_idx] = 1'b0;
        if (legal) free_nxt[free_ptr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // bit 0 is the null pointer and is never owned by the pool
            free_r <= ~ptr_d_t'(1);
            alloc_vld_r <= 1'b0;
            alloc_ptr_r <= PTR_NULL;
            free_cnt_r <= CNT_MAX;
            err_bad_r <= 1'b0;
            err_dbl_r <= 1'b0;
        end else begin
            free_r <= free_nxt;
            if (refill) begin
                alloc_vld_r <= pick_vld;
                alloc_ptr_r <= pick_vld ? pick_idx : PTR_NULL;
            end
            free_cnt_r <= free_cnt_r + cnt_t'(legal) - cnt_t'(hs);
            err_bad_r <= err_bad_r | bad;
            err_dbl_r <= err_dbl_r | dbl;
        end
    end

    assign alloc_vld = alloc_vld_r;
    assign alloc_ptr = alloc_ptr_r;
    assign free_cnt = free_cnt_r;
    assign err_bad_ptr = err_bad_r;
    assign err_dbl_free = err_dbl_r;
endmodule
